// File: rtl/shot_clock_pkg.sv
// Shared state encoding and reload digits for the shot clock controller.
package shot_clock_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_LOAD    = 3'd1,
    S_IDLE    = 3'd2,
    S_RUN     = 3'd3,
    S_PAUSED  = 3'd4,
    S_EXPIRED = 3'd5
  } state_t;

  localparam logic [3:0] RELOAD24_T = 4'd2;
  localparam logic [3:0] RELOAD24_O = 4'd4;
  localparam logic [3:0] RELOAD14_T = 4'd1;
  localparam logic [3:0] RELOAD14_O = 4'd4;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the 1 s count tick; holds its phase while not running.
module tick_prescaler #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (run)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot clock sequencer: drives load/enable of an external BCD down-counter pair,
// watches its outputs for 00 and runs the buzzer after expiry.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int CLK_DIV     = 50_000_000,
  parameter int BUZZ_CYCLES = 100_000_000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       RST24,
  input  logic       RST14,
  input  logic [3:0] Q_TENS,
  input  logic [3:0] Q_ONES,
  output logic       PE,
  output logic       CEP,
  output logic [3:0] D_TENS,
  output logic [3:0] D_ONES,
  output logic       RUNNING,
  output logic       EXPIRED,
  output logic       BUZZ
);

  localparam int BW = $clog2(BUZZ_CYCLES + 1);

  state_t        state, nxt;
  logic          tgt14, nxt_tgt14;   // 0: reload 24, 1: reload 14
  logic [BW-1:0] buzz_cnt;
  logic          tick;
  logic          q_zero;

  assign q_zero = (Q_TENS == 4'd0) && (Q_ONES == 4'd0);

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .clk   (CP),
    .rst   (CR),
    .run   (state == S_RUN),
    .clear ((state == S_LOAD) || (state == S_INIT)),
    .tick  (tick)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state <= S_INIT;
      tgt14 <= 1'b0;
    end else begin
      state <= nxt;
      tgt14 <= nxt_tgt14;
    end
  end

  always_comb begin
    nxt       = state;
    nxt_tgt14 = tgt14;
    if (state == S_INIT) begin
      nxt = S_LOAD;
    end else if (RST24) begin
      nxt       = S_LOAD;
      nxt_tgt14 = 1'b0;
    end else if (RST14) begin
      nxt       = S_LOAD;
      nxt_tgt14 = 1'b1;
    end else begin
      unique case (state)
        S_LOAD:   nxt = S_IDLE;
        S_IDLE:   if (START) nxt = S_RUN;
        S_RUN:    if (PAUSE) nxt = S_PAUSED;
                  else if (q_zero) nxt = S_EXPIRED;
        S_PAUSED: if (START) nxt = S_RUN;
        default:  nxt = state;
      endcase
    end
  end

  // Counter is loaded on entry to EXPIRED and cleared by any exit from it.
  always_ff @(posedge CP or posedge CR) begin
    if (CR)
      buzz_cnt <= '0;
    else if (nxt != S_EXPIRED)
      buzz_cnt <= '0;
    else if (state != S_EXPIRED)
      buzz_cnt <= BW'(BUZZ_CYCLES);
    else if (buzz_cnt != '0)
      buzz_cnt <= buzz_cnt - BW'(1);
  end

  assign PE      = (state != S_LOAD);
  assign CEP     = tick && !q_zero;
  assign D_TENS  = tgt14 ? RELOAD14_T : RELOAD24_T;
  assign D_ONES  = tgt14 ? RELOAD14_O : RELOAD24_O;
  assign RUNNING = (state == S_RUN);
  assign EXPIRED = (state == S_EXPIRED);
  assign BUZZ    = (buzz_cnt != '0);

endmodule
